// File: rtl/background_scroller_m.sv
// background_scroller_m: scanline background layer for the GPU.
// During hblank the fetch FSM walks one line of nametable tiles, pulls the
// matching pattern line from PMB and stores {colour, 16-bit line} per tile
// into the back half of a double-buffered line buffer. On the next line the
// halves swap and the front half is streamed out pixel by pixel.
// Optional feature macro: BG_SCROLL_EN enables pixel-granular X/Y scrolling
// with wrap-around and the extra (COLS+1)th tile needed for fine X scroll.
module background_scroller_m #(
    parameter int COLS      = 32,
    parameter int ROWS      = 30,
    parameter int PATTERNS  = 32,
    parameter int COLOR_IDX = 960
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [7:0]  yp,
    input  logic [7:0]  xp,
    input  logic        visible,
    input  logic        writable,
    input  logic [7:0]  scroll_x,
    input  logic [7:0]  scroll_y,
    input  logic        we,
    input  logic [11:0] address,
    input  logic [7:0]  data,
    output logic [1:0]  r,
    output logic [1:0]  g,
    output logic [1:0]  b,
    output logic        fetch_busy,
    output logic        fetch_overrun
);

    localparam int CB       = $clog2(COLS);
    localparam int PB       = $clog2(PATTERNS);
    localparam int PMB_AW   = PB + 4;
    localparam int PMB_SIZE = PATTERNS * 16;
    localparam int SLOTS    = COLS + 1;
    localparam int TW       = $clog2(COLS + 1);
    localparam logic [9:0] COLOR_ADDR = 10'(COLOR_IDX);
`ifdef BG_SCROLL_EN
    localparam int LAST_TILE = COLS;
`else
    localparam int LAST_TILE = COLS - 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_NT,
        S_PH,
        S_PL,
        S_DONE
    } state_t;

    logic [7:0]  pmb [PMB_SIZE];
    logic [7:0]  ntbl [1024];
    logic [18:0] line_buf [2][SLOTS];

    state_t        state;
    logic [TW-1:0] tile_i;
    logic          front_sel;
    logic          front_valid;
    logic          back_valid;

    logic [2:0] fx_q;
    logic [4:0] cx_q;
    logic [4:0] row_q;
    logic [2:0] ty_q;

    logic [PB-1:0] pat_q;
    logic          hflip_q;
    logic          vflip_q;
    logic [2:0]    colour_q;
    logic [7:0]    hi_q;

    logic [2:0]  fx_next;
    logic [4:0]  cx_next;
    logic [7:0]  wy;
    logic [CB-1:0] col_idx;
    logic [9:0]  nt_addr;
    logic [7:0]  tile_rd;
    logic [7:0]  creg_rd;
    logic [2:0]  ty_eff;
    logic [7:0]  lo_rd;
    logic [15:0] raw_line;
    logic [15:0] flip_line;
    logic [15:0] fetched_line;
    logic        buf_we;

    logic [8:0]  pix_pos;
    logic [5:0]  slot;
    logic [2:0]  px;
    logic [18:0] slot_word;
    logic [1:0]  pixel;
    logic [2:0]  pix_colour;

    logic unused_bits;

`ifdef BG_SCROLL_EN
    logic [8:0] wy_sum;
    assign unused_bits = ^{address[10], creg_rd[7:6]};
`else
    assign unused_bits = ^{address[10], creg_rd[7:6], scroll_x, scroll_y};
`endif

    // VRAM write port: bit 11 of the address picks nametable or pattern memory
    always_ff @(posedge clk) begin
        if (we && writable) begin
            if (address[11]) begin
                ntbl[address[9:0]] <= data;
            end else begin
                pmb[address[PMB_AW-1:0]] <= data;
            end
        end
    end

    // Scroll-adjusted world coordinates captured when a new line fetch begins
    always_comb begin
`ifdef BG_SCROLL_EN
        wy_sum  = {1'b0, yp} + {1'b0, scroll_y};
        wy      = (wy_sum >= 9'(ROWS * 8)) ? 8'(wy_sum - 9'(ROWS * 8)) : wy_sum[7:0];
        fx_next = scroll_x[2:0];
        cx_next = scroll_x[7:3];
`else
        wy      = yp;
        fx_next = 3'd0;
        cx_next = 5'd0;
`endif
    end

    // Fetch datapath: nametable address, pattern address and flipped pattern line
    always_comb begin
        col_idx   = CB'(TW'(cx_q) + tile_i);
        nt_addr   = 10'({row_q, col_idx});
        tile_rd   = ntbl[nt_addr];
        creg_rd   = ntbl[COLOR_ADDR];
        ty_eff    = vflip_q ? ~ty_q : ty_q;
        lo_rd     = pmb[{pat_q, ty_eff, 1'b1}];
        raw_line  = {hi_q, lo_rd};
        flip_line = '0;
        for (int k = 0; k < 8; k++) begin
            flip_line[2*k +: 2] = raw_line[2*(7-k) +: 2];
        end
        fetched_line = hflip_q ? flip_line : raw_line;
        buf_we       = rst && !line_start && (state == S_PL);
    end

    // Fetch FSM: buffer swap / overrun handling on line_start, then NT-PH-PL per tile
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            tile_i        <= '0;
            front_sel     <= 1'b0;
            front_valid   <= 1'b0;
            back_valid    <= 1'b0;
            fetch_busy    <= 1'b0;
            fetch_overrun <= 1'b0;
            fx_q          <= 3'd0;
            cx_q          <= 5'd0;
            row_q         <= 5'd0;
            ty_q          <= 3'd0;
        end else begin
            fetch_overrun <= 1'b0;
            if (line_start) begin
                fx_q       <= fx_next;
                cx_q       <= cx_next;
                row_q      <= wy[7:3];
                ty_q       <= wy[2:0];
                tile_i     <= '0;
                state      <= S_NT;
                fetch_busy <= 1'b1;
                if (state == S_IDLE) begin
                    front_sel   <= ~front_sel;
                    front_valid <= back_valid;
                    back_valid  <= 1'b0;
                end else begin
                    fetch_overrun <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_NT: begin
                        pat_q    <= tile_rd[PB-1:0];
                        hflip_q  <= tile_rd[6];
                        vflip_q  <= tile_rd[5];
                        colour_q <= tile_rd[7] ? creg_rd[5:3] : creg_rd[2:0];
                        state    <= S_PH;
                    end
                    S_PH: begin
                        hi_q  <= pmb[{pat_q, ty_eff, 1'b0}];
                        state <= S_PL;
                    end
                    S_PL: begin
                        if (tile_i == TW'(LAST_TILE)) begin
                            state <= S_DONE;
                        end else begin
                            tile_i <= tile_i + 1'b1;
                            state  <= S_NT;
                        end
                    end
                    S_DONE: begin
                        back_valid <= 1'b1;
                        fetch_busy <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Back-buffer write of the completed tile line at the end of each PL step
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[~front_sel][tile_i] <= {colour_q, fetched_line};
        end
    end

    // Front-buffer pixel lookup for the current screen column
    always_comb begin
        pix_pos    = {1'b0, xp} + {6'd0, fx_q};
        slot       = pix_pos[8:3];
        px         = pix_pos[2:0];
        slot_word  = line_buf[front_sel][slot];
        pixel      = slot_word[{~px, 1'b0} +: 2];
        pix_colour = slot_word[18:16];
    end

    // Registered colour output, blanked outside active video or without a valid line
    always_ff @(posedge clk) begin
        if (!rst) begin
            r <= 2'd0;
            g <= 2'd0;
            b <= 2'd0;
        end else if (visible && front_valid) begin
            r <= pixel & {2{pix_colour[2]}};
            g <= pixel & {2{pix_colour[1]}};
            b <= pixel & {2{pix_colour[0]}};
        end else begin
            r <= 2'd0;
            g <= 2'd0;
            b <= 2'd0;
        end
    end

endmodule

// File: tb/tb_background_scroller_m.sv
// tb_background_scroller_m: directed, table-driven bench for background_scroller_m.
// Pixel vectors live in a table; fetch timing, overrun and write-collision
// behaviour are driven by hand-written sequences. Expectations follow the
// BG_SCROLL_EN setting the design is built with.
`timescale 1ns/1ps
module tb_background_scroller_m;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  yp = 8'd0;
    logic [7:0]  xp = 8'd0;
    logic        visible = 1'b0;
    logic        writable = 1'b0;
    logic [7:0]  scroll_x = 8'd0;
    logic [7:0]  scroll_y = 8'd0;
    logic        we = 1'b0;
    logic [11:0] address = 12'd0;
    logic [7:0]  data = 8'd0;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
    logic        fetch_busy;
    logic        fetch_overrun;

    int assertions = 0;
    int failures = 0;

`ifdef BG_SCROLL_EN
    localparam int FETCH_LEN = 100;
`else
    localparam int FETCH_LEN = 97;
`endif

    typedef struct {
        string      name;
        int         phase;
        logic [7:0] x;
        logic       vis;
        logic [1:0] er;
        logic [1:0] eg;
        logic [1:0] eb;
    } vec_t;

    vec_t vecs[$];

    background_scroller_m dut (
        .clk           (clk),
        .rst           (rst),
        .line_start    (line_start),
        .yp            (yp),
        .xp            (xp),
        .visible       (visible),
        .writable      (writable),
        .scroll_x      (scroll_x),
        .scroll_y      (scroll_y),
        .we            (we),
        .address       (address),
        .data          (data),
        .r             (r),
        .g             (g),
        .b             (b),
        .fetch_busy    (fetch_busy),
        .fetch_overrun (fetch_overrun)
    );

    // Free-running pixel clock
    always #5 clk = ~clk;

    function automatic void add_pix(string name, int phase, int x, int vis, int pix);
        vec_t v;
        v.name  = name;
        v.phase = phase;
        v.x     = 8'(x);
        v.vis   = 1'(vis);
        v.er    = 2'd0;
        v.eg    = 2'(pix);
        v.eb    = 2'(pix);
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic vis);
        @(negedge clk);
        xp      = x;
        visible = vis;
    endtask

    task automatic run_phase(input int phase);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == phase) begin
                applyStimulus(vecs[i].x, vecs[i].vis);
                @(negedge clk);
                checkOutput({vecs[i].name, "_r"}, int'(r), int'(vecs[i].er));
                checkOutput({vecs[i].name, "_g"}, int'(g), int'(vecs[i].eg));
                checkOutput({vecs[i].name, "_b"}, int'(b), int'(vecs[i].eb));
            end
        end
        visible = 1'b0;
    endtask

    task automatic vram_write(input logic [11:0] addr, input logic [7:0] d, input logic wr);
        @(negedge clk);
        address  = addr;
        data     = d;
        we       = 1'b1;
        writable = wr;
        @(negedge clk);
        we       = 1'b0;
        writable = 1'b0;
    endtask

    task automatic pulse_line(input logic [7:0] y, input logic [7:0] sx, input logic [7:0] sy);
        @(negedge clk);
        line_start = 1'b1;
        yp         = y;
        scroll_x   = sx;
        scroll_y   = sy;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_fetch(output int busy_n, output int ovr_n);
        busy_n = 0;
        ovr_n  = 0;
        for (int c = 0; c < 400; c++) begin
            if (fetch_overrun) ovr_n++;
            if (!fetch_busy) break;
            busy_n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int o;

        add_pix("pre_swap0", 0, 0, 1, 0);
        add_pix("pre_swap3", 0, 3, 1, 0);
        add_pix("pre_swap7", 0, 7, 1, 0);

        add_pix("basic0", 1, 0, 1, 3);
        add_pix("basic1", 1, 1, 1, 0);
        add_pix("basic2", 1, 2, 1, 3);
        add_pix("basic3", 1, 3, 1, 0);
        add_pix("basic4", 1, 4, 1, 3);
        add_pix("basic5", 1, 5, 1, 0);
        add_pix("basic6", 1, 6, 1, 3);
        add_pix("basic7", 1, 7, 1, 0);
        add_pix("basic8", 1, 8, 1, 3);
        add_pix("basic_invis", 1, 0, 0, 0);

        add_pix("flip0", 2, 0, 1, 0);
        add_pix("flip3", 2, 3, 1, 0);
        add_pix("flip4", 2, 4, 1, 3);
        add_pix("flip5", 2, 5, 1, 2);
        add_pix("flip6", 2, 6, 1, 1);
        add_pix("flip7", 2, 7, 1, 0);

        add_pix("ovr_front4", 3, 4, 1, 3);
        add_pix("ovr_front5", 3, 5, 1, 2);
        add_pix("ovr_front6", 3, 6, 1, 1);

        add_pix("ovr_next0", 4, 0, 1, 3);
        add_pix("ovr_next1", 4, 1, 1, 0);

        add_pix("coll_old41", 5, 41, 1, 0);
        add_pix("coll_old42", 5, 42, 1, 3);
        add_pix("coll_nowr49", 5, 49, 1, 0);

        add_pix("coll_new41", 6, 41, 1, 3);
        add_pix("coll_new42", 6, 42, 1, 0);
        add_pix("coll_nowr49b", 6, 49, 1, 0);

`ifdef BG_SCROLL_EN
        add_pix("scroll_x0", 7, 0, 1, 2);
        add_pix("scroll_x1", 7, 1, 1, 1);
        add_pix("scroll_x2", 7, 2, 1, 0);
        add_pix("scroll_x3", 7, 3, 1, 3);
        add_pix("scroll_x4", 7, 4, 1, 2);
`else
        add_pix("noscroll_x0", 7, 0, 1, 3);
        add_pix("noscroll_x1", 7, 1, 1, 2);
        add_pix("noscroll_x2", 7, 2, 1, 1);
        add_pix("noscroll_x3", 7, 3, 1, 0);
        add_pix("noscroll_x8", 7, 8, 1, 0);
        add_pix("noscroll_x9", 7, 9, 1, 1);
`endif

        // Reset held with visible high and a stray line_start
        rst        = 1'b0;
        visible    = 1'b1;
        xp         = 8'd3;
        line_start = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_r", int'(r), 0);
        checkOutput("reset_g", int'(g), 0);
        checkOutput("reset_b", int'(b), 0);
        checkOutput("reset_busy", int'(fetch_busy), 0);
        checkOutput("reset_overrun", int'(fetch_overrun), 0);
        line_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", int'(fetch_busy), 0);
        run_phase(0);

        // Pattern memory: p1 rows 0/6/7, p2 rows 0/6 (high byte first)
        vram_write(12'd16, 8'hCC, 1'b1);
        vram_write(12'd17, 8'hCC, 1'b1);
        vram_write(12'd28, 8'hE4, 1'b1);
        vram_write(12'd29, 8'h1B, 1'b1);
        vram_write(12'd30, 8'h1B, 1'b1);
        vram_write(12'd31, 8'h00, 1'b1);
        vram_write(12'd32, 8'hF0, 1'b1);
        vram_write(12'd33, 8'h0F, 1'b1);
        vram_write(12'd44, 8'h1B, 1'b1);
        vram_write(12'd45, 8'hE4, 1'b1);
        vram_write(12'h800 + 12'd960, 8'h33, 1'b1);
        for (int i = 0; i < 32; i++) begin
            vram_write(12'h800 + 12'(i), 8'h01, 1'b1);
        end
        vram_write(12'h800 + 12'd896, 8'h01, 1'b1);
        vram_write(12'h800 + 12'd897, 8'h02, 1'b1);

        // Basic line: first fetch length, then swap and sweep
        pulse_line(8'd0, 8'd0, 8'd0);
        wait_fetch(n, o);
        checkOutput("busy_len_first", n, FETCH_LEN);
        checkOutput("no_overrun_first", o, 0);
        pulse_line(8'd0, 8'd0, 8'd0);
        wait_fetch(n, o);
        checkOutput("busy_len_second", n, FETCH_LEN);
        run_phase(1);

        // Flipped tile in column 0
        vram_write(12'h800, 8'h61, 1'b1);
        pulse_line(8'd0, 8'd0, 8'd0);
        wait_fetch(n, o);
        checkOutput("busy_len_flip_a", n, FETCH_LEN);
        pulse_line(8'd0, 8'd0, 8'd0);
        wait_fetch(n, o);
        checkOutput("busy_len_flip_b", n, FETCH_LEN);
        run_phase(2);

        // Overrun: second line_start 50 clocks into a fetch
        vram_write(12'h800, 8'h01, 1'b1);
        pulse_line(8'd0, 8'd0, 8'd0);
        repeat (48) @(negedge clk);
        checkOutput("ovr_busy_before", int'(fetch_busy), 1);
        pulse_line(8'd0, 8'd0, 8'd0);
        wait_fetch(n, o);
        checkOutput("ovr_restart_len", n, FETCH_LEN);
        checkOutput("ovr_pulse_count", o, 1);
        run_phase(3);
        pulse_line(8'd0, 8'd0, 8'd0);
        wait_fetch(n, o);
        checkOutput("busy_len_after_ovr", n, FETCH_LEN);
        run_phase(4);

        // Discarded write, then a write colliding with the NT read of tile 5
        vram_write(12'h806, 8'h02, 1'b0);
        pulse_line(8'd0, 8'd0, 8'd0);
        repeat (15) @(negedge clk);
        address  = 12'h805;
        data     = 8'h02;
        we       = 1'b1;
        writable = 1'b1;
        @(negedge clk);
        we       = 1'b0;
        writable = 1'b0;
        wait_fetch(n, o);
        checkOutput("busy_len_coll_rest", n, FETCH_LEN - 16);
        pulse_line(8'd0, 8'd0, 8'd0);
        wait_fetch(n, o);
        checkOutput("busy_len_coll_next", n, FETCH_LEN);
        run_phase(5);
        pulse_line(8'd0, 8'd0, 8'd0);
        wait_fetch(n, o);
        checkOutput("busy_len_coll_after", n, FETCH_LEN);
        run_phase(6);

        // Scroll with horizontal and vertical wrap
        vram_write(12'h800 + 12'd31, 8'h02, 1'b1);
        pulse_line(8'd230, 8'hFD, 8'd16);
        wait_fetch(n, o);
        checkOutput("busy_len_scroll_a", n, FETCH_LEN);
        pulse_line(8'd230, 8'hFD, 8'd16);
        wait_fetch(n, o);
        checkOutput("busy_len_scroll_b", n, FETCH_LEN);
        run_phase(7);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/background_scroller_m.md
Name: background_scroller_m

Overview:
- Next-generation background layer.
- Fetches one scanline of nametable/pattern data into a double-buffered line buffer during horizontal blank, then streams pixels out on the following line.
- Adds pixel-granular X/Y scrolling with wrap-around and parametrised nametable geometry.
- Sits in the GPU beside the sprite engine and feeds the pixel mixer.

Parameters:
- COLS, 32, nametable columns (power of 2); line buffer holds COLS+1 tiles.
- ROWS, 30, nametable rows; vertical world height = ROWS*8 lines.
- PATTERNS, 32, background patterns (power of 2); PMB = PATTERNS*16 bytes.
- COLOR_IDX, 960, NTBL byte index of the global colour register ([2:0] colour0, [5:3] colour1).

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  synchronous reset, active-low.
- line_start  in  1  one-cycle pulse at start of hblank; begins fetch of line `yp`.
- yp  in  8  screen line to fetch (the next visible line).
- xp  in  8  current screen pixel column.
- visible  in  1  active-video flag.
- writable  in  1  VRAM write window.
- scroll_x  in  8  horizontal scroll, sampled at line_start.
- scroll_y  in  8  vertical scroll, sampled at line_start.
- we  in  1  VRAM write strobe.
- address  in  12  VRAM address: [11]=0 → PMB[address[8:0]]; [11]=1 → NTBL[address[9:0]].
- data  in  8  VRAM write data.
- r, g, b  out  2 each  pixel colour.
- fetch_busy  out  1  fetch FSM not idle.
- fetch_overrun  out  1  one-cycle pulse when line_start hits a busy fetch.

Behaviour:
- Reset (rst==0 at clk edge):
  - FSM→IDLE.
  - front_valid=0, back_valid=0.
  - r/g/b=0, fetch_busy=0, fetch_overrun=0.
  - Memories are not cleared.
- Writes: when we && writable, write on that clock edge.
  - A fetch read of the same address in the same cycle returns the old byte.
- On line_start, latch:
  - fx = scroll_x[2:0], cx = scroll_x[7:3];
  - wy = yp + scroll_y; if wy ≥ ROWS*8, subtract ROWS*8 (single subtraction; inputs keep the sum < 2*ROWS*8);
  - row = wy[7:3], ty = wy[2:0].
- FSM states: IDLE → NT → PH → PL → (next tile or DONE) → IDLE. Tile counter i = 0..COLS.
  - NT: read NTBL[row*COLS + ((cx+i) mod COLS)] and NTBL[COLOR_IDX].
  - PH: read PMB high byte of line ty' (ty' = vflip ? 7−ty : ty).
  - PL: read low byte; apply hflip by reversing the eight 2-bit pixels; write {colour, 16-bit line} into back buffer slot i.
  - DONE: back_valid=1.
- Fetch length: 3*(COLS+1)+1 cycles (100 for COLS=32).
- line_start handling:
  - FSM in IDLE: swap buffers (front_valid←back_valid, back_valid←0), then start fetch.
  - FSM busy: pulse fetch_overrun, no swap, restart fetch at i=0 with newly latched values.
  - line_start during reset: ignored.
- Pixel output (registered, latency 1 clock from xp/visible):
  - p = xp + fx (9-bit), slot = p[8:3], px = p[2:0].
  - pixel = 2-bit field (7−px) of slot line.
  - r = pixel & {2{colour[2]}}; g and b likewise with colour[1], colour[0].
  - Output is 0 when !visible or !front_valid.
- Horizontal wrap: column (cx+i) mod COLS.
- Vertical wrap: scroll_y=16, yp=230 → wy=6, row 0.

Optional Feature:
- Macro BG_SCROLL_EN.
- Defined: scrolling as above; fetch covers COLS+1 tiles.
- Undefined:
  - scroll_x and scroll_y are ignored (treated as 0) and fx=0.
  - Fetch covers COLS tiles only (97 cycles for COLS=32).
  - Wrap subtraction logic is removed.

Test Plan:
- Reset: hold rst=0 with visible=1 for 4 clocks → r=g=b=0, fetch_busy=0. Release, then xp sweep before first swap → outputs 0.
- Basic line:
  - Setup: PMB pattern 1 row 0 = 16'hCCCC; NTBL[0..31]=8'h01; colour reg=8'b110_011.
  - Sequence: line_start yp=0, wait 100 clocks, line_start again, xp=0..7.
  - Expected: output 1 clock later, g=b={3,0,3,0,3,0,3,0}, r=0.
  - fetch_busy high exactly 100 cycles.
- Flip:
  - Setup: tile byte 8'h61 (hflip, vflip, pmba 1); pattern 1 row 7 = 16'h1B00; fetch yp=0.
  - Expected: pixels 0..7 = 0,0,0,0,3,2,1,0.
- Scroll wrap:
  - Setup: scroll_x=8'hFD, scroll_y=16, yp=230.
  - Expected: fetch reads row 0 starting at column 31; xp=0 shows column-31 pixel 5; xp=3 shows column-0 pixel 0.
- Overrun: second line_start 50 clocks after the first → fetch_overrun=1 for one cycle, no swap (front content unchanged), fetch restarts and completes 100 clocks later.
- Write collision: write NTBL[5]=8'h02 in the same cycle the FSM reads it → current line uses the old tile; the next fetch uses pattern 2. A write with writable=0 is discarded.
